// File: rtl/sha3_stim_harness.sv
// sha3_stim_harness: LFSR message source and MISR digest sink for
// out-of-context hash cores (sha3_high_throughput and successors).
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   run                 level; start/continue message generation
//   core_in             message word to the core (lfsr value in SEND)
//   core_in_ready       word valid; every asserted cycle is a transfer
//   core_is_last        current word closes its message
//   core_byte_num       valid bytes in the last word, else 0
//   core_buffer_full    core back-pressure; gates core_in_ready
//   core_out            digest from the core
//   core_out_ready      digest strobe; always folded into sig
//   sig                 rotating XOR signature of all digests
//   msg_count           digests received (wraps)
//   busy                FSM not idle
//   err                 sticky watchdog flag
//
// Build option: define SHA3_HARNESS_TIMEOUT_EN to add a WAIT_OUT watchdog
// of TIMEOUT cycles; without it err is held at 0 and WAIT_OUT never expires.

module sha3_stim_harness #(
    parameter int                DATA_W        = 64,
    parameter int                OUT_W         = 512,
    parameter int                SIG_W         = 32,
    parameter int                MSG_WORDS_MAX = 4,
    parameter logic [DATA_W-1:0] SEED          = DATA_W'(64'h1),
    parameter logic [DATA_W-1:0] POLY          =
        DATA_W'(64'hD800_0000_0000_0000),
    parameter int                TIMEOUT       = 1024,
    localparam int               BN_W          =
        (DATA_W > 8) ? $clog2(DATA_W / 8) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic [DATA_W-1:0] core_in,
    output logic              core_in_ready,
    output logic              core_is_last,
    output logic [BN_W-1:0]   core_byte_num,
    input  logic              core_buffer_full,
    input  logic [OUT_W-1:0]  core_out,
    input  logic              core_out_ready,
    output logic [SIG_W-1:0]  sig,
    output logic [15:0]       msg_count,
    output logic              busy,
    output logic              err
);

    localparam int LEN_W  =
        (MSG_WORDS_MAX > 1) ? $clog2(MSG_WORDS_MAX) : 1;
    localparam int WL_W   = $clog2(MSG_WORDS_MAX + 1);
    localparam int NSLICE = OUT_W / SIG_W;

    // An all-zero Galois LFSR would lock up, so a zero seed becomes 1.
    localparam logic [DATA_W-1:0] SEED_EFF =
        (SEED == '0) ? DATA_W'(1) : SEED;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LEN  = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_WAIT = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] lfsr_q, lfsr_d;
    logic [WL_W-1:0]   wl_q, wl_d;
    logic [SIG_W-1:0]  sig_q, sig_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] lfsr_step;
    logic [WL_W-1:0]   len_val;
    logic [SIG_W-1:0]  fold;
    logic              in_send;
    logic              is_last;
    logic              xfer;
    logic              timeout;

    assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ POLY)
                                 : (lfsr_q >> 1);

    always_comb begin
        len_val = WL_W'(1);
        if (MSG_WORDS_MAX > 1) begin
            len_val = WL_W'(lfsr_q[LEN_W-1:0]) + WL_W'(1);
        end
    end

    always_comb begin
        fold = '0;
        for (int i = 0; i < NSLICE; i++) begin
            fold = fold ^ core_out[i*SIG_W +: SIG_W];
        end
    end

    // Outputs decode straight from registered state, so reset clears
    // them without waiting for a clock edge.
    assign in_send = (state_q == S_SEND);
    assign is_last = in_send && (wl_q == WL_W'(1));
    assign xfer    = in_send && !core_buffer_full;

    assign core_in       = in_send ? lfsr_q : '0;
    assign core_in_ready = xfer;
    assign core_is_last  = is_last;
    assign core_byte_num = is_last ? lfsr_q[BN_W-1:0] : '0;
    assign busy          = (state_q != S_IDLE);
    assign sig           = sig_q;
    assign msg_count     = cnt_q;
    assign err           = err_q;

`ifdef SHA3_HARNESS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] to_q, to_d;

    assign timeout = (state_q == S_WAIT) && !core_out_ready &&
                     (to_q == TO_W'(TIMEOUT - 1));

    always_comb begin
        to_d = to_q;
        if (state_q != S_WAIT) begin
            to_d = '0;
        end else begin
            to_d = to_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_q <= '0;
        end else begin
            to_q <= to_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        wl_d    = wl_q;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                wl_d    = len_val;
                lfsr_d  = lfsr_step;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (xfer) begin
                    lfsr_d = lfsr_step;
                    wl_d   = wl_q - WL_W'(1);
                    if (is_last) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (core_out_ready || timeout) begin
                    state_d = run ? S_LEN : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Digests are folded in whatever state they arrive.
    always_comb begin
        sig_d = sig_q;
        cnt_d = cnt_q;
        if (core_out_ready) begin
            sig_d = {sig_q[SIG_W-2:0], sig_q[SIG_W-1]} ^ fold;
            cnt_d = cnt_q + 16'd1;
        end
    end

    assign err_d = err_q | timeout;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED_EFF;
            wl_q    <= '0;
            sig_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            wl_q    <= wl_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_sha3_stim_harness.sv
// tb_sha3_stim_harness: directed tables, hand sequences and a randomized
// scoreboard run against sha3_stim_harness.

module tb_sha3_stim_harness;

    localparam logic [63:0] POLY   = 64'hD800_0000_0000_0000;
    localparam logic [63:0] SEED_A = 64'h3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, run, bf, ordy;
    logic [511:0] cout;
    logic [63:0]  cin;
    logic         crdy, clast, busy, err;
    logic [2:0]   cbn;
    logic [31:0]  sig;
    logic [15:0]  mcnt;

    logic         run1, bf1, ordy1;
    logic [63:0]  cin1;
    logic         crdy1, clast1, busy1, err1;
    logic [2:0]   cbn1;
    logic [31:0]  sig1;
    logic [15:0]  mcnt1;

    sha3_stim_harness #(
        .MSG_WORDS_MAX(4),
        .SEED(SEED_A),
        .TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset), .run(run),
        .core_in(cin), .core_in_ready(crdy),
        .core_is_last(clast), .core_byte_num(cbn),
        .core_buffer_full(bf), .core_out(cout),
        .core_out_ready(ordy), .sig(sig),
        .msg_count(mcnt), .busy(busy), .err(err)
    );

    sha3_stim_harness #(
        .MSG_WORDS_MAX(1),
        .SEED(64'h0),
        .TIMEOUT(16)
    ) dut1 (
        .clk(clk), .reset(reset), .run(run1),
        .core_in(cin1), .core_in_ready(crdy1),
        .core_is_last(clast1), .core_byte_num(cbn1),
        .core_buffer_full(bf1), .core_out(cout),
        .core_out_ready(ordy1), .sig(sig1),
        .msg_count(mcnt1), .busy(busy1), .err(err1)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    function automatic logic [63:0] step(input logic [63:0] v);
        return v[0] ? ((v >> 1) ^ POLY) : (v >> 1);
    endfunction

    function automatic logic [31:0] misr(input logic [31:0] s,
                                         input logic [511:0] d);
        logic [31:0] r;
        r = {s[30:0], s[31]};
        for (int i = 0; i < 16; i++) r = r ^ d[i*32 +: 32];
        return r;
    endfunction

    // Expected transfer stream: each message consumes one LFSR value for
    // its length, then one value per word.
    typedef struct {
        logic [63:0] w;
        logic        last;
        logic [2:0]  bn;
    } xfer_t;

    xfer_t       exq[$];
    logic [63:0] m;

    function automatic void gen_msg();
        int    len;
        xfer_t x;
        len = int'(m[1:0]) + 1;
        m   = step(m);
        for (int k = 0; k < len; k++) begin
            x.w    = m;
            x.last = (k == len - 1);
            x.bn   = x.last ? m[2:0] : 3'd0;
            exq.push_back(x);
            m = step(m);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic take_word(input string tag, output int waited,
                             output logic last);
        xfer_t x;
        if (exq.size() == 0) gen_msg();
        x      = exq.pop_front();
        waited = 0;
        @(negedge clk);
        while (!crdy && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, " rdy"}, crdy, 1);
        chk({tag, " data"}, cin, x.w);
        chk({tag, " last"}, clast, x.last);
        chk({tag, " bn"}, cbn, x.bn);
        last = x.last;
        tick();
    endtask

    typedef struct {
        logic [511:0] d;
        logic [31:0]  s;
        logic [15:0]  c;
    } mv_t;

    mv_t tbl[5];

    // Scoreboard for the randomized phase.
    logic        sb_en = 1'b0;
    logic [31:0] sm;
    logic [15:0] cm;
    xfer_t       mx;

    always @(negedge clk) begin
        if (sb_en) begin
            chk("rnd full gate", 64'(crdy & bf), 0);
            chk("rnd sig", sig, sm);
            chk("rnd cnt", mcnt, cm);
            if (crdy) begin
                if (exq.size() == 0) gen_msg();
                mx = exq.pop_front();
                chk("rnd data", cin, mx.w);
                chk("rnd last", clast, mx.last);
                chk("rnd bn", cbn, mx.bn);
            end
            if (ordy) begin
                sm = misr(sm, cout);
                cm = cm + 16'd1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t;
        logic        lst;
        logic [63:0] w;
        logic [31:0] s_m;

        tbl[0] = '{{512{1'b1}}, 32'h0, 16'd1};
        tbl[1] = '{512'h1, 32'h1, 16'd2};
        tbl[2] = '{512'h1, 32'h3, 16'd3};
        tbl[3] = '{{16{32'h1}}, 32'h6, 16'd4};
        tbl[4] = '{512'h8000_0000, 32'h8000_000C, 16'd5};

        reset = 1'b0; run = 1'b0; bf = 1'b0; ordy = 1'b0;
        cout = '0; run1 = 1'b0; bf1 = 1'b0; ordy1 = 1'b0;

        // Reset values
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst core_in", cin, 0);
        chk("rst rdy", crdy, 0);
        chk("rst last", clast, 0);
        chk("rst bn", cbn, 0);
        chk("rst sig", sig, 0);
        chk("rst cnt", mcnt, 0);
        chk("rst busy", busy, 0);
        chk("rst err", err, 0);
        chk("rst1 rdy", crdy1, 0);
        tick();
        reset = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("idle busy", busy, 0);
        chk("idle rdy", crdy, 0);

        // MISR table
        for (int i = 0; i < 5; i++) begin
            tick();
            ordy = 1'b1;
            cout = tbl[i].d;
            tick();
            ordy = 1'b0;
            @(negedge clk);
            chk($sformatf("misr%0d sig", i), sig, tbl[i].s);
            chk($sformatf("misr%0d cnt", i), mcnt, tbl[i].c);
        end
        chk("misr busy", busy, 0);
        s_m = tbl[4].s;

        // Single-word messages, zero seed replaced by 1
        m = 64'h1;
        tick();
        run1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            m = step(m);
            w = m;
            m = step(m);
            t = 0;
            @(negedge clk);
            while (!crdy1 && t < 10) begin
                @(negedge clk);
                t++;
            end
            chk("m1 rdy", crdy1, 1);
            chk("m1 last", clast1, 1);
            chk("m1 data", cin1, w);
            tick();
            ordy1 = 1'b1;
            tick();
            ordy1 = 1'b0;
        end
        run1 = 1'b0;
        chk("m1 cnt", mcnt1, 3);

        // 4-word message, latency, back-pressure, run drop
        m = SEED_A;
        exq.delete();
        tick();
        run = 1'b1;
        tick();
        @(negedge clk);
        chk("len busy", busy, 1);
        chk("len rdy", crdy, 0);
        take_word("w0", t, lst);
        chk("len latency", t, 0);
        run = 1'b0;
        bf  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bf rdy", crdy, 0);
            chk("bf data", cin, exq[0].w);
            tick();
        end
        bf = 1'b0;
        take_word("w1", t, lst);
        chk("bf release", t, 0);
        take_word("w2", t, lst);
        chk("w2 notlast", lst, 0);
        take_word("w3", t, lst);
        chk("w3 last", lst, 1);
        @(negedge clk);
        chk("wait busy", busy, 1);
        chk("wait rdy", crdy, 0);
        tick();
        ordy = 1'b1;
        cout = 512'h5;
        s_m  = misr(s_m, 512'h5);
        tick();
        ordy = 1'b0;
        @(negedge clk);
        chk("drop idle", busy, 0);
        chk("drop sig", sig, s_m);
        chk("drop cnt", mcnt, 6);

        // Watchdog
        tick();
        run = 1'b1;
        lst = 1'b0;
        for (int k = 0; k < 4 && !lst; k++) take_word("t5", t, lst);
        chk("t5 ended", lst, 1);
        repeat (15) tick();
        @(negedge clk);
        chk("t5 err early", err, 0);
        chk("t5 busy", busy, 1);
        tick();
        @(negedge clk);
        chk("t5 rdy16", crdy, 0);
`ifdef SHA3_HARNESS_TIMEOUT_EN
        chk("t5 err", err, 1);
        tick();
        @(negedge clk);
        chk("t5 len->send", crdy, 1);
`else
        chk("t5 err", err, 0);
        tick();
        @(negedge clk);
        chk("t5 still wait", crdy, 0);
        chk("t5 still busy", busy, 1);
        chk("t5 err late", err, 0);
        tick();
        ordy = 1'b1;
        tick();
        ordy = 1'b0;
        t = 0;
        @(negedge clk);
        while (!crdy && t < 20) begin
            @(negedge clk);
            t++;
        end
`endif
        // Asynchronous reset in SEND
        chk("pre-rst rdy", crdy, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst rdy", crdy, 0);
        chk("arst core_in", cin, 0);
        chk("arst last", clast, 0);
        chk("arst bn", cbn, 0);
        chk("arst busy", busy, 0);
        chk("arst sig", sig, 0);
        chk("arst cnt", mcnt, 0);
        chk("arst err", err, 0);

        // Randomized run against the scoreboard
        tick();
        m = SEED_A;
        exq.delete();
        sm = '0;
        cm = '0;
        tick();
        reset = 1'b1;
        run   = 1'b1;
        sb_en = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            bf   = ($urandom_range(0, 2) == 0);
            ordy = ($urandom_range(0, 4) == 0);
            for (int j = 0; j < 16; j++) cout[j*32 +: 32] = $urandom;
            tick();
        end
        sb_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
